// File: rtl/polar_pkg.sv
// Shared types and helpers for the polar leaf decoder and partial-sum unit.
// Node-type and FSM encodings, default LLR width, sign/abs helpers.
package polar_pkg;

    localparam int LLR_W_DEF = 20;
    // Helpers work on a widened value so any LLR_W below this can use them.
    localparam int LLR_MAX_W = 32;

    typedef enum logic [1:0] {
        NT_RATE0 = 2'd0,
        NT_RATE1 = 2'd1,
        NT_REP   = 2'd2,
        NT_SPC   = 2'd3
    } node_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FINAL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic llr_sign(input logic [LLR_MAX_W-1:0] v);
        return ($signed(v) < 0);
    endfunction

    // The most negative narrow LLR maps to a positive value that still fits the narrow width.
    function automatic logic [LLR_MAX_W-1:0] llr_abs(input logic [LLR_MAX_W-1:0] v);
        return v[LLR_MAX_W-1] ? (~v + LLR_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/polar_butterfly.sv
// Combinational polar transform u = x * F^{(x)log2N}, F = [1 0; 1 1].
// Self-inverse; shared with the partial-sum unit.
module polar_butterfly
    import polar_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] u
);

    localparam int LOG2N = $clog2(N);

    logic [N-1:0] v;
    int           lo;
    int           hi;

    // Stage s pairs index lo (bit s clear) with lo + 2^s and folds the upper into the lower.
    always_comb begin
        v  = x;
        lo = 0;
        hi = 0;
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                lo    = ((b >> s) << (s + 1)) | (b & ((1 << s) - 1));
                hi    = lo + (1 << s);
                v[lo] = v[lo] ^ v[hi];
            end
        end
        u = v;
    end

endmodule

// File: rtl/polar_leaf_decoder.sv
// Multi-cycle SC polar leaf decoder: classifies the frozen mask, scans one LLR
// per cycle and returns the N decoded u bits over a valid/ready handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | in_ready=1, waiting for a request; capture on in_valid
//   ST_SCAN  | accumulate hard decision, sum, parity, min magnitude, one LLR per cycle
//   ST_FINAL | build codeword, transform to u, register results, raise out_valid
//   ST_HOLD  | outputs frozen until out_ready
module polar_leaf_decoder
    import polar_pkg::*;
#(
    parameter int LLR_W = LLR_W_DEF,
    parameter int N     = 4,
    parameter int LOG2N = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*LLR_W-1:0] llr,
    input  logic [N-1:0]       frozen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       u,
    output logic [1:0]         node_type,
    output logic               err
);

    localparam int               SUM_W    = LLR_W + LOG2N;
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
    localparam logic [N-1:0]     MASK_REP = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]     MASK_SPC = N'(1);
    localparam logic [LLR_W-1:0] MAG_INIT = '1;

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               scan;
    logic               fin;
    logic               rel;

    logic [N*LLR_W-1:0] llr_q;
    logic [N-1:0]       frozen_q;
    logic [LOG2N-1:0]   idx;
    logic [N-1:0]       h_q;
    logic [SUM_W-1:0]   sum_q;
    logic               parity_q;
    logic [LLR_W-1:0]   min_mag_q;
    logic [LOG2N-1:0]   min_idx_q;

    logic [LLR_W-1:0]     cur;
    logic [LLR_MAX_W-1:0] cur_ext;
    logic [LLR_MAX_W-1:0] mag_full;
    logic [LLR_W-1:0]     cur_mag;
    logic                 cur_h;
    logic [SUM_W-1:0]     cur_sum_ext;
    logic                 unused_mag_hi;

    node_type_t         nt_next;
    logic               err_next;
    logic [N-1:0]       x_cw;
    logic [N-1:0]       u_bf;
    logic [N-1:0]       u_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        scan       = 1'b0;
        fin        = 1'b0;
        rel        = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                scan = 1'b1;
                if (idx == IDX_LAST) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                fin        = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    rel        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cur           = llr_q[int'(idx) * LLR_W +: LLR_W];
    assign cur_ext       = {{(LLR_MAX_W - LLR_W){cur[LLR_W-1]}}, cur};
    assign cur_h         = llr_sign(cur_ext);
    assign mag_full      = llr_abs(cur_ext);
    assign cur_mag       = mag_full[LLR_W-1:0];
    assign unused_mag_hi = ^mag_full[LLR_MAX_W-1:LLR_W];
    assign cur_sum_ext   = {{LOG2N{cur[LLR_W-1]}}, cur};

    // Strict less-than keeps the lower index on a magnitude tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            llr_q     <= '0;
            frozen_q  <= '0;
            idx       <= '0;
            h_q       <= '0;
            sum_q     <= '0;
            parity_q  <= 1'b0;
            min_mag_q <= MAG_INIT;
            min_idx_q <= '0;
            out_valid <= 1'b0;
            u         <= '0;
            node_type <= NT_RATE0;
            err       <= 1'b0;
        end else begin
            if (load) begin
                llr_q     <= llr;
                frozen_q  <= frozen;
                idx       <= '0;
                h_q       <= '0;
                sum_q     <= '0;
                parity_q  <= 1'b0;
                min_mag_q <= MAG_INIT;
                min_idx_q <= '0;
            end
            if (scan) begin
                h_q[idx] <= cur_h;
                sum_q    <= sum_q + cur_sum_ext;
                parity_q <= parity_q ^ cur_h;
                if (cur_mag < min_mag_q) begin
                    min_mag_q <= cur_mag;
                    min_idx_q <= idx;
                end
                idx <= idx + LOG2N'(1);
            end
            if (fin) begin
                out_valid <= 1'b1;
                u         <= u_next;
                node_type <= nt_next;
                err       <= err_next;
            end
            if (rel) begin
                out_valid <= 1'b0;
            end
        end
    end

    // REP is tested before SPC so that N=2 with mask 01 lands on REP.
    always_comb begin
        nt_next  = NT_RATE1;
        err_next = 1'b0;
        if (&frozen_q) begin
            nt_next = NT_RATE0;
        end else if (frozen_q == '0) begin
            nt_next = NT_RATE1;
        end else if (frozen_q == MASK_REP) begin
            nt_next = NT_REP;
        end else if (frozen_q == MASK_SPC) begin
            nt_next = NT_SPC;
        end else begin
            err_next = 1'b1;
        end

        x_cw = '0;
        case (nt_next)
            NT_RATE0: x_cw = '0;
            NT_RATE1: x_cw = err_next ? '0 : h_q;
            NT_REP:   x_cw = {N{sum_q[SUM_W-1]}};
            NT_SPC:   x_cw = h_q ^ (N'(parity_q) << min_idx_q);
            default:  x_cw = '0;
        endcase
    end

    polar_butterfly #(
        .N(N)
    ) u_butterfly (
        .x(x_cw),
        .u(u_bf)
    );

    assign u_next = err_next ? '0 : (u_bf & ~frozen_q);

endmodule

// File: tb/tb_polar_leaf_decoder.sv
// Self-checking bench for polar_leaf_decoder: N=4 and N=2 instances, directed
// cases plus random leaves checked against a bit-level reference model.
module tb_polar_leaf_decoder;

    logic        clk;
    logic        rst;

    logic        iv4, rdy4, ov4, or4, er4;
    logic [79:0] llr4;
    logic [3:0]  fz4, u4;
    logic [1:0]  nt4;

    logic        iv2, rdy2, ov2, or2, er2;
    logic [39:0] llr2;
    logic [1:0]  fz2, u2;
    logic [1:0]  nt2;

    int checks;
    int failures;

    polar_leaf_decoder #(.LLR_W(20), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .llr(llr4),
        .frozen(fz4), .out_valid(ov4), .out_ready(or4), .u(u4),
        .node_type(nt4), .err(er4)
    );

    polar_leaf_decoder #(.LLR_W(20), .N(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .llr(llr2),
        .frozen(fz2), .out_valid(ov2), .out_ready(or2), .u(u2),
        .node_type(nt2), .err(er2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Reference: classify, derive codeword from sign/sum/parity/min rules, then
    // u[j] = XOR of x[i] over all i whose bit set contains j's (row expansion of F^(x)n).
    task automatic model(input int n, input int l[4], input int fz,
                         output int mu, output int mnt, output int merr);
        int all, sum, minm, mi, hv, x, m, par, b;
        all  = (1 << n) - 1;
        mu   = 0;
        merr = 0;
        if (fz == all)             mnt = 0;
        else if (fz == 0)          mnt = 1;
        else if (fz == (all >> 1)) mnt = 2;
        else if (fz == 1)          mnt = 3;
        else begin
            mnt  = 1;
            merr = 1;
            return;
        end
        sum = 0; minm = 1 << 30; mi = 0; hv = 0;
        for (int i = 0; i < n; i++) begin
            if (l[i] < 0) hv |= (1 << i);
            sum += l[i];
            m = (l[i] < 0) ? -l[i] : l[i];
            if (m < minm) begin
                minm = m;
                mi   = i;
            end
        end
        par = $countones(hv) & 1;
        case (mnt)
            0:       x = 0;
            1:       x = hv;
            2:       x = (sum < 0) ? all : 0;
            default: x = par ? (hv ^ (1 << mi)) : hv;
        endcase
        for (int j = 0; j < n; j++) begin
            b = 0;
            for (int i = 0; i < n; i++)
                if ((j & ~i) == 0) b ^= (x >> i) & 1;
            if (b != 0 && ((fz >> j) & 1) == 0) mu |= (1 << j);
        end
    endtask

    task automatic run4(input int l[4], input int fz, output int mu);
        int mnt, merr, cyc;
        model(4, l, fz, mu, mnt, merr);
        cyc = 0;
        while (!rdy4 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("rdy4_before_req", 32'(rdy4), 32'd1);
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) llr4[i*20 +: 20] = l[i][19:0];
        fz4 = fz[3:0];
        @(posedge clk); #1;
        iv4 = 1'b0;
        for (int i = 0; i < 4; i++) llr4[i*20 +: 20] = 20'($urandom);
        fz4 = 4'($urandom);
        cyc = 0;
        while (!ov4 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("lat4", 32'(cyc), 32'd5);
        check("u4", 32'(u4), 32'(mu));
        check("nt4", 32'(nt4), 32'(mnt));
        check("err4", 32'(er4), 32'(merr));
        if (or4) begin
            @(posedge clk); #1;
            check("done4_ov", 32'(ov4), 32'd0);
            check("done4_rdy", 32'(rdy4), 32'd1);
        end
    endtask

    task automatic run2(input int l[4], input int fz, output int mu);
        int mnt, merr, cyc;
        model(2, l, fz, mu, mnt, merr);
        cyc = 0;
        while (!rdy2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("rdy2_before_req", 32'(rdy2), 32'd1);
        iv2 = 1'b1;
        for (int i = 0; i < 2; i++) llr2[i*20 +: 20] = l[i][19:0];
        fz2 = fz[1:0];
        @(posedge clk); #1;
        iv2 = 1'b0;
        for (int i = 0; i < 2; i++) llr2[i*20 +: 20] = 20'($urandom);
        fz2 = 2'($urandom);
        cyc = 0;
        while (!ov2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("lat2", 32'(cyc), 32'd3);
        check("u2", 32'(u2), 32'(mu));
        check("nt2", 32'(nt2), 32'(mnt));
        check("err2", 32'(er2), 32'(merr));
        @(posedge clk); #1;
        check("done2_ov", 32'(ov2), 32'd0);
    endtask

    function automatic int rand_llr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 8)) - 4;
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    initial begin
        int lv[4];
        int mu, saw, sel, fz;
        checks = 0; failures = 0;
        rst = 1'b1;
        iv4 = 0; or4 = 1; llr4 = '0; fz4 = '0;
        iv2 = 0; or2 = 1; llr2 = '0; fz2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rdy4", 32'(rdy4), 32'd1);
        check("rst_ov4", 32'(ov4), 32'd0);
        check("rst_u4", 32'(u4), 32'd0);
        check("rst_nt4", 32'(nt4), 32'd0);
        check("rst_err4", 32'(er4), 32'd0);
        check("rst_rdy2", 32'(rdy2), 32'd1);
        check("rst_ov2", 32'(ov2), 32'd0);

        lv = '{5, -3, 0, 0};
        run2(lv, 0, mu);
        check("tp_n2_rate1_u", 32'(u2), 32'd3);
        check("tp_n2_rate1_nt", 32'(nt2), 32'd1);

        lv = '{4, -9, 2, -1};
        run4(lv, 4'b0111, mu);
        check("tp_rep_u", 32'(u4), 32'b1000);
        check("tp_rep_nt", 32'(nt4), 32'd2);

        lv = '{-6, 3, 3, 8};
        run4(lv, 4'b0001, mu);
        check("tp_spc_u", 32'(u4), 32'b0010);
        check("tp_spc_nt", 32'(nt4), 32'd3);

        lv = '{-3, 3, 5, 5};
        run4(lv, 4'b0001, mu);
        check("tp_spc_tie_u", 32'(u4), 32'b0000);

        lv = '{-524288, 524287, -524288, -524287};
        run4(lv, 4'b0001, mu);
        check("spc_maxneg_u", 32'(u4), 32'b1000);

        lv = '{rand_llr(), rand_llr(), rand_llr(), rand_llr()};
        run4(lv, 4'b1111, mu);
        check("tp_rate0_u", 32'(u4), 32'd0);
        check("tp_rate0_nt", 32'(nt4), 32'd0);

        lv = '{-7, 2, -1, 9};
        run4(lv, 4'b1010, mu);
        check("tp_err_flag", 32'(er4), 32'd1);
        check("tp_err_u", 32'(u4), 32'd0);

        lv = '{-524288, 0, 0, 0};
        run2(lv, 0, mu);
        check("tp_n2_maxneg_u", 32'(u2), 32'b01);

        lv = '{3, -1, 0, 0};
        run2(lv, 1, mu);
        check("tp_n2_rep_nt", 32'(nt2), 32'd2);

        // Backpressure: result held, in_valid pulses ignored while busy.
        or4 = 1'b0;
        lv = '{-6, 3, 3, 8};
        run4(lv, 4'b0001, mu);
        for (int k = 0; k < 5; k++) begin
            iv4 = 1'b1;
            for (int i = 0; i < 4; i++) llr4[i*20 +: 20] = 20'($urandom);
            fz4 = 4'($urandom);
            @(posedge clk); #1;
            check("bp_ov", 32'(ov4), 32'd1);
            check("bp_u", 32'(u4), 32'(mu));
            check("bp_rdy", 32'(rdy4), 32'd0);
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", 32'(ov4), 32'd0);
        check("bp_release_rdy", 32'(rdy4), 32'd1);
        @(posedge clk); #1;
        check("bp_no_stale_accept", 32'(rdy4), 32'd1);
        lv = '{4, -9, 2, -1};
        run4(lv, 4'b0111, mu);

        // Reset in the middle of a scan discards the request.
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) llr4[i*20 +: 20] = 20'($urandom);
        fz4 = 4'b0000;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_scan_rdy", 32'(rdy4), 32'd1);
        check("rst_scan_ov", 32'(ov4), 32'd0);
        saw = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov4) saw = 1;
        end
        check("rst_scan_no_result", 32'(saw), 32'd0);
        lv = '{-6, 3, 3, 8};
        run4(lv, 4'b0001, mu);

        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: fz = 4'b1111;
                1: fz = 4'b0000;
                2: fz = 4'b0111;
                3: fz = 4'b0001;
                default: fz = int'($urandom_range(0, 15));
            endcase
            lv = '{rand_llr(), rand_llr(), rand_llr(), rand_llr()};
            run4(lv, fz, mu);
        end
        for (int k = 0; k < 15; k++) begin
            lv = '{rand_llr(), rand_llr(), 0, 0};
            run2(lv, int'($urandom_range(0, 3)), mu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
